// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Number of result bits produced by each pipeline stage.
    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational S-bit ripple-carry slice built from full-adder cells.
module addsub_slice #(
    parameter int S = 8
) (
    input  logic [S-1:0] a_s,
    input  logic [S-1:0] b_s,
    input  logic         c_in,
    output logic [S-1:0] sum_s,
    output logic         c_out
);

    logic [S:0] c;

    // Full-adder cells chained LSB to MSB; bit i consumes the carry of bit i-1.
    always_comb begin
        c     = '0;
        sum_s = '0;
        c[0]  = c_in;
        for (int i = 0; i < S; i++) begin
            sum_s[i] = a_s[i] ^ b_s[i] ^ c[i];
            c[i+1]   = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
        end
        c_out = c[S];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES slices; each stage resolves one slice and forwards its carry, the
// finished low sum bits and the still-unprocessed high operand bits.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int S = slice_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] cry;

    // Subtraction is a + ~b + ~cin, so cin acts as an active-high borrow-in.
    assign b_eff    = (sub == MODE_ADD) ? b : ~b;
    assign c_eff    = (sub == MODE_SUB) ? ~cin : cin;
    assign in_ready = ld[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W = WIDTH - k * S;
        localparam int LO   = (k + 1) * S;

        logic [IN_W-1:0] a_in;
        logic [IN_W-1:0] b_in;
        logic            c_in;
        logic            v_in;
        logic            c_out;
        logic [S-1:0]    slice_sum;
        logic [LO-1:0]   s_nx;
        logic [LO-1:0]   s_r;
        logic            v_r;
        logic            c_r;

        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = b_eff;
            assign c_in = c_eff;
            assign v_in = in_valid;
            assign s_nx = slice_sum;
        end else begin : g_next
            assign a_in = g_stage[k-1].g_hi.ah_r;
            assign b_in = g_stage[k-1].g_hi.bh_r;
            assign c_in = cry[k-1];
            assign v_in = vld[k-1];
            assign s_nx = {slice_sum, g_stage[k-1].s_r};
        end

        addsub_slice #(.S(S)) u_slice (
            .a_s   (a_in[S-1:0]),
            .b_s   (b_in[S-1:0]),
            .c_in  (c_in),
            .sum_s (slice_sum),
            .c_out (c_out)
        );

        // A stage may load unless it and every stage downstream is full with a stalled head.
        assign ld[k]  = out_ready | ~(&vld[STAGES-1:k]);
        assign vld[k] = v_r;
        assign cry[k] = c_r;

        // Valid bit: bubbles are loaded too, which is what lets gaps collapse.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_r <= 1'b0;
            end else if (ld[k]) begin
                v_r <= v_in;
            end
        end

        // Carry and finished low sum bits; only captured for real beats.
        always_ff @(posedge clk) begin
            if (reset) begin
                c_r <= 1'b0;
                s_r <= '0;
            end else if (ld[k] && v_in) begin
                c_r <= c_out;
                s_r <= s_nx;
            end
        end

        if (k < STAGES - 1) begin : g_hi
            logic [IN_W-S-1:0] ah_r;
            logic [IN_W-S-1:0] bh_r;

            // Skew registers: operand bits not yet consumed ride along with the beat.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ah_r <= '0;
                    bh_r <= '0;
                end else if (ld[k] && v_in) begin
                    ah_r <= a_in[IN_W-1:S];
                    bh_r <= b_in[IN_W-1:S];
                end
            end
        end else begin : g_last
            logic ovf_r;
            logic zero_r;

            // Flags are registered alongside the sum so they stay zero after reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (ld[k] && v_in) begin
                    ovf_r  <= (a_in[IN_W-1] == b_in[IN_W-1]) && (slice_sum[S-1] != a_in[IN_W-1]);
                    zero_r <= ~|s_nx;
                end
            end

            assign sum       = s_r;
            assign cout      = c_r;
            assign ovf       = ovf_r;
            assign zero      = zero_r;
            assign out_valid = v_r;
        end
    end

endmodule
